// File: rtl/relu_maxpool_stage.sv
// ----------------------------------------------------------------------------
// relu_maxpool_stage
//   Post-PE-array stage: applies ReLU to the biased conv outputs of three
//   filters and 2x2 max-pools them. Each input beat carries one conv column
//   for two vertically adjacent rows (r, r+1). Two consecutive beats (an EVEN
//   column and the ODD column after it) form one pooling window. The stage
//   emits one pooled value per filter for each window, tagged with the pooled
//   row/col indices used by the downstream feature-map buffer.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_i         in   synchronous reset, active-high
//   clear_i       in   synchronous soft clear, same effect as rst_i
//   valid_i       in   conv_in1..3 carry one column this cycle
//   conv_in1..3   in   [1:0][DATA_W-1:0] signed samples, [0]=row r, [1]=row r+1
//   valid_o       out  one-cycle pulse, pool_out/indices are new
//   pool_out      out  [2:0][DATA_W-1:0] pooled value per filter ([0]=filter 1), >= 0
//   pool_col_o    out  pooled column index of pool_out
//   pool_row_o    out  pooled row index of pool_out
//   frame_done_o  out  pulses with valid_o on the last pooled pixel of a frame
// ----------------------------------------------------------------------------
module relu_maxpool_stage #(
   parameter  int DATA_W = 12,
   parameter  int CONV_W = 24,
   parameter  int CONV_H = 24,
   localparam int PC_W   = ($clog2(CONV_W/2) > 0) ? $clog2(CONV_W/2) : 1,
   localparam int PR_W   = ($clog2(CONV_H/2) > 0) ? $clog2(CONV_H/2) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         valid_i,
   input  logic [1:0][DATA_W-1:0]       conv_in1,
   input  logic [1:0][DATA_W-1:0]       conv_in2,
   input  logic [1:0][DATA_W-1:0]       conv_in3,
   output logic                         valid_o,
   output logic [2:0][DATA_W-1:0]       pool_out,
   output logic [PC_W-1:0]              pool_col_o,
   output logic [PR_W-1:0]              pool_row_o,
   output logic                         frame_done_o
);

   localparam int CC_W = ($clog2(CONV_W) > 0) ? $clog2(CONV_W) : 1;
   localparam logic [CC_W-1:0] COL_LAST = CC_W'(CONV_W - 1);
   localparam logic [PR_W-1:0] ROW_LAST = PR_W'(CONV_H/2 - 1);

   if ((CONV_W % 2) != 0) begin : g_bad_w
      $error("relu_maxpool_stage: CONV_W must be even");
   end
   if ((CONV_H % 2) != 0) begin : g_bad_h
      $error("relu_maxpool_stage: CONV_H must be even");
   end

   typedef enum logic {
      PH_EVEN = 1'b0,
      PH_ODD  = 1'b1
   } phase_t;

   // Sign bit decides: negative samples clamp to zero, width is unchanged.
   function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? '0 : DATA_W'(x);
   endfunction

   // Operands are post-ReLU (non-negative), so an unsigned compare is exact.
   function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   phase_t                   r_phase;
   phase_t                   w_phase_nxt;
   logic [CC_W-1:0]          r_col_cnt;
   logic [PR_W-1:0]          r_row_cnt;
   logic [CC_W-1:0]          w_col_nxt;
   logic [PR_W-1:0]          w_row_nxt;
   logic                     w_last;
   logic [PC_W-1:0]          w_col_half;
   logic                     w_emit;

   logic [2:0][1:0][DATA_W-1:0] w_raw;
   logic [2:0][DATA_W-1:0]   w_pair_max;
   logic [2:0][DATA_W-1:0]   w_pool;
   logic [2:0][DATA_W-1:0]   r_m;

   logic                     r_valid;
   logic                     r_frame_done;
   logic [2:0][DATA_W-1:0]   r_pool;
   logic [PC_W-1:0]          r_pool_col;
   logic [PR_W-1:0]          r_pool_row;

   assign w_raw = {conv_in3, conv_in2, conv_in1};

   // Datapath: per-filter column max and full-window max.
   always_comb begin
      w_pair_max = '0;
      w_pool     = '0;
      for (int f = 0; f < 3; f++) begin
         w_pair_max[f] = max2(relu(w_raw[f][0]), relu(w_raw[f][1]));
         w_pool[f]     = max2(r_m[f], w_pair_max[f]);
      end
   end

   // Phase FSM next state plus counter next values (shared across filters).
   always_comb begin
      w_phase_nxt = r_phase;
      w_col_nxt   = r_col_cnt;
      w_row_nxt   = r_row_cnt;
      w_emit      = 1'b0;
      w_last      = (r_col_cnt == COL_LAST) && (r_row_cnt == ROW_LAST);
      w_col_half  = PC_W'(r_col_cnt >> 1);
      if (valid_i) begin
         w_phase_nxt = (r_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
         w_emit      = (r_phase == PH_ODD);
         if (r_col_cnt == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + PR_W'(1);
         end else begin
            w_col_nxt = r_col_cnt + CC_W'(1);
         end
      end
   end

   // Control and output registers; clear_i behaves exactly like rst_i and
   // drops any beat presented in the same cycle, discarding a partial window.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_phase      <= PH_EVEN;
         r_col_cnt    <= '0;
         r_row_cnt    <= '0;
         r_valid      <= 1'b0;
         r_frame_done <= 1'b0;
         r_pool       <= '0;
         r_pool_col   <= '0;
         r_pool_row   <= '0;
      end else begin
         r_phase      <= w_phase_nxt;
         r_col_cnt    <= w_col_nxt;
         r_row_cnt    <= w_row_nxt;
         r_valid      <= w_emit;
         r_frame_done <= w_emit && w_last;
         if (w_emit) begin
            r_pool     <= w_pool;
            r_pool_col <= w_col_half;
            r_pool_row <= r_row_cnt;
         end
      end
   end

   // First-column max of the window; only meaningful while phase is ODD,
   // so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (valid_i && (r_phase == PH_EVEN)) begin
         r_m <= w_pair_max;
      end
   end

   assign valid_o      = r_valid;
   assign frame_done_o = r_frame_done;
   assign pool_out     = r_pool;
   assign pool_col_o   = r_pool_col;
   assign pool_row_o   = r_pool_row;

endmodule

// File: tb/tb_relu_maxpool_stage.sv
module tb_relu_maxpool_stage;

   localparam int DATA_W = 12;
   localparam int CONV_W = 24;
   localparam int CONV_H = 24;
   localparam int PC_W   = 4;
   localparam int PR_W   = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   clr;
   logic                   vin;
   logic [1:0][DATA_W-1:0] c1, c2, c3;
   logic                   vo;
   logic [2:0][DATA_W-1:0] po;
   logic [PC_W-1:0]        pcol;
   logic [PR_W-1:0]        prow;
   logic                   fd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   relu_maxpool_stage #(
      .DATA_W(DATA_W), .CONV_W(CONV_W), .CONV_H(CONV_H)
   ) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(vin),
      .conv_in1(c1), .conv_in2(c2), .conv_in3(c3),
      .valid_o(vo), .pool_out(po), .pool_col_o(pcol), .pool_row_o(prow),
      .frame_done_o(fd)
   );

   // One pooling window: beat0 (rows 0,1) and beat1 (rows 0,1) per filter,
   // then the expected pooled value per filter.
   typedef struct packed {
      logic [DATA_W-1:0] f1a, f1b, f1c, f1d;
      logic [DATA_W-1:0] f2a, f2b, f2c, f2d;
      logic [DATA_W-1:0] f3a, f3b, f3c, f3d;
      logic [DATA_W-1:0] e1, e2, e3;
   } vec_t;

   vec_t vecs[5];

   function automatic vec_t mk(input int a, b, c, d, e, f, g, h, i, j, k, l,
                               input int x, y, z);
      vec_t v;
      v.f1a = DATA_W'(a); v.f1b = DATA_W'(b); v.f1c = DATA_W'(c); v.f1d = DATA_W'(d);
      v.f2a = DATA_W'(e); v.f2b = DATA_W'(f); v.f2c = DATA_W'(g); v.f2d = DATA_W'(h);
      v.f3a = DATA_W'(i); v.f3b = DATA_W'(j); v.f3c = DATA_W'(k); v.f3d = DATA_W'(l);
      v.e1  = DATA_W'(x); v.e2  = DATA_W'(y); v.e3  = DATA_W'(z);
      return v;
   endfunction

   function automatic int relu_m(input int v);
      return (v < 0) ? 0 : v;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int a0, a1, b0, b1, d0, d1);
      vin   = 1'b1;
      c1[0] = DATA_W'(a0); c1[1] = DATA_W'(a1);
      c2[0] = DATA_W'(b0); c2[1] = DATA_W'(b1);
      c3[0] = DATA_W'(d0); c3[1] = DATA_W'(d1);
      step();
      vin = 1'b0;
   endtask

   task automatic idle();
      vin = 1'b0;
      step();
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got 0, expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      int vld_cnt;
      int fd_cnt;
      int mx[3];
      int k0, k1, k2, k3, k4, k5;

      rst = 1'b1; clr = 1'b0; vin = 1'b0;
      c1 = '0; c2 = '0; c3 = '0;

      vecs[0] = mk(5, -3, 7, 2,   -1, -1, -1, -1,   0, 0, 0, 0,   7, 0, 0);
      vecs[1] = mk(-100, -100, -100, -100,  -100, -100, -100, -100,
                   -100, -100, -100, -100,  0, 0, 0);
      vecs[2] = mk(2047, -2048, 0, 1,  -2048, -2048, -2048, 1,  10, 10, 10, 10,
                   2047, 1, 10);
      vecs[3] = mk(1, 9, 4, -2,   3, 8, 8, 3,   -5, 6, -7, -8,   9, 8, 6);
      vecs[4] = mk(0, 0, 0, 100,  50, -1, 49, -1,  -1, 2046, 2047, -1,
                   100, 50, 2047);

      // Reset state
      step(); step();
      rst = 1'b0;
      check("rst_valid", 32'(vo), 0);
      check("rst_pool0", 32'(po[0]), 0);
      check("rst_pool2", 32'(po[2]), 0);
      check("rst_col", 32'(pcol), 0);
      check("rst_row", 32'(prow), 0);
      check("rst_fdone", 32'(fd), 0);

      // Table: back-to-back windows, pooled column advances by one each
      for (int i = 0; i < 5; i++) begin
         beat(int'($signed(vecs[i].f1a)), int'($signed(vecs[i].f1b)),
              int'($signed(vecs[i].f2a)), int'($signed(vecs[i].f2b)),
              int'($signed(vecs[i].f3a)), int'($signed(vecs[i].f3b)));
         check($sformatf("v%0d_even_valid", i), 32'(vo), 0);
         beat(int'($signed(vecs[i].f1c)), int'($signed(vecs[i].f1d)),
              int'($signed(vecs[i].f2c)), int'($signed(vecs[i].f2d)),
              int'($signed(vecs[i].f3c)), int'($signed(vecs[i].f3d)));
         check($sformatf("v%0d_valid", i), 32'(vo), 1);
         check($sformatf("v%0d_pool1", i), 32'(po[0]), 32'(vecs[i].e1));
         check($sformatf("v%0d_pool2", i), 32'(po[1]), 32'(vecs[i].e2));
         check($sformatf("v%0d_pool3", i), 32'(po[2]), 32'(vecs[i].e3));
         check($sformatf("v%0d_col", i), 32'(pcol), 32'(i));
         check($sformatf("v%0d_row", i), 32'(prow), 0);
         check($sformatf("v%0d_fdone", i), 32'(fd), 0);
      end
      idle();
      check("tbl_pulse_end", 32'(vo), 0);
      check("tbl_hold_pool", 32'(po[2]), 2047);

      // Gap of 4 idle cycles inside a window (col counter is at 10 here)
      beat(1, 9, 0, 0, 0, 0);
      check("gap_first", 32'(vo), 0);
      for (int g = 0; g < 4; g++) begin
         idle();
         check($sformatf("gap_idle%0d", g), 32'(vo), 0);
      end
      beat(4, -2, 0, 0, 0, 0);
      check("gap_valid", 32'(vo), 1);
      check("gap_pool", 32'(po[0]), 9);
      check("gap_col", 32'(pcol), 5);
      idle();
      check("gap_pulse", 32'(vo), 0);
      check("gap_hold", 32'(po[0]), 9);

      // Clear mid-pair discards the partial max
      beat(99, 99, 99, 99, 99, 99);
      clr = 1'b1;
      idle();
      clr = 1'b0;
      check("clr_valid", 32'(vo), 0);
      check("clr_pool", 32'(po[0]), 0);
      check("clr_col", 32'(pcol), 0);
      beat(3, 3, 0, 0, 0, 0);
      check("clr_even", 32'(vo), 0);
      beat(8, 1, 0, 0, 0, 0);
      check("clr_out_valid", 32'(vo), 1);
      check("clr_out_pool", 32'(po[0]), 8);
      check("clr_out_pool2", 32'(po[1]), 0);
      check("clr_out_col", 32'(pcol), 0);
      check("clr_out_row", 32'(prow), 0);

      // Full frame of 24 x 12 beats with ramp data
      clr = 1'b1;
      idle();
      clr = 1'b0;
      vld_cnt = 0;
      fd_cnt  = 0;
      mx      = '{0, 0, 0};
      for (int k = 0; k < CONV_W * CONV_H / 2; k++) begin
         k0 = k - 100;
         k1 = ((k * 37) % 300) - 150;
         k2 = -k;
         k3 = -1;
         k4 = 287 - k;
         k5 = k % 5;
         beat(k0, k1, k2, k3, k4, k5);
         if (vo) vld_cnt++;
         if (fd) fd_cnt++;
         if ((k % 2) == 0) begin
            mx[0] = imax(relu_m(k0), relu_m(k1));
            mx[1] = imax(relu_m(k2), relu_m(k3));
            mx[2] = imax(relu_m(k4), relu_m(k5));
            check($sformatf("frm_even_valid%0d", k), 32'(vo), 0);
         end else begin
            mx[0] = imax(mx[0], imax(relu_m(k0), relu_m(k1)));
            mx[1] = imax(mx[1], imax(relu_m(k2), relu_m(k3)));
            mx[2] = imax(mx[2], imax(relu_m(k4), relu_m(k5)));
            check($sformatf("frm_valid%0d", k), 32'(vo), 1);
            check($sformatf("frm_pool1_%0d", k), 32'(po[0]), 32'(mx[0]));
            check($sformatf("frm_pool2_%0d", k), 32'(po[1]), 32'(mx[1]));
            check($sformatf("frm_pool3_%0d", k), 32'(po[2]), 32'(mx[2]));
            check($sformatf("frm_col%0d", k), 32'(pcol), 32'((k / 2) % 12));
            check($sformatf("frm_row%0d", k), 32'(prow), 32'((k / 2) / 12));
            check($sformatf("frm_fdone%0d", k), 32'(fd), 32'((k / 2) == 143));
         end
      end
      check("frm_valid_count", 32'(vld_cnt), 144);
      check("frm_fdone_count", 32'(fd_cnt), 1);

      // Next frame restarts indices at (0,0)
      beat(5, 6, 0, 0, 0, 0);
      check("nxt_even", 32'(vo), 0);
      beat(1, 2, 0, 0, 0, 0);
      check("nxt_valid", 32'(vo), 1);
      check("nxt_pool", 32'(po[0]), 6);
      check("nxt_col", 32'(pcol), 0);
      check("nxt_row", 32'(prow), 0);
      check("nxt_fdone", 32'(fd), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
